change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream stage of `ticket_shop`. Takes the change amount the shop computes on `out_cash` and pays it out as physical coins through a hopper, one coin at a time. Uses greedy selection over the 50/10/5/1 coin set and a per-coin valid/ack handshake with a timeout. Reports progress, completion and hopper faults back to the front panel.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles `coin_valid` may wait for `coin_ack` before a fault.
- `V3`, 50: value of coin type 3.
- `V2`, 10: value of coin type 2.
- `V1`, 5: value of coin type 1.
- `V0`, 1: value of coin type 0.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; samples `amount`.
- `amount`  in  32  change to pay, unsigned; connected to `ticket_shop.out_cash`.
- `coin_ack`  in  1  hopper has ejected the offered coin.
- `coin_valid`  out  1  a coin is being offered to the hopper.
- `coin_type`  out  2  offered coin: 3=`V3`, 2=`V2`, 1=`V1`, 0=`V0`.
- `busy`  out  1  a payout is in progress.
- `done`  out  1  one-cycle pulse when a payout ends, whether it succeeds or faults.
- `fault`  out  1  sticky flag: the last payout aborted on timeout.
- `remaining`  out  32  change still owed.
- `coin_count`  out  32  coins ejected in the current or last payout.

## Operation
- States: IDLE, SELECT, EMIT, FINISH.
- **IDLE**
  - `start`=1: load `remaining`←`amount`, clear `coin_count` and `fault`.
  - Go to FINISH if `amount`==0, otherwise go to SELECT.
- **SELECT** (one cycle)
  - Register `coin_type` as the largest denomination with value ≤ `remaining`, checked in order V3, V2, V1, V0.
  - Clear the timeout counter and go to EMIT.
- **EMIT**
  - `coin_valid`=1 and `coin_type` are held stable.
  - On an edge with `coin_ack`=1: `remaining`←`remaining`−value, `coin_count`+1.
    - If the new `remaining` is 0, go to FINISH; otherwise go to SELECT.
  - Otherwise the timeout counter increments.
    - When it reaches `TIMEOUT`−1 with `coin_ack` still 0: set `fault`=1, leave `remaining` unchanged, go to FINISH.
- **FINISH**: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in SELECT, EMIT and FINISH; it is 0 only in IDLE.
- `start` is ignored outside IDLE; `amount` is sampled only on the accepted edge.
- `coin_ack` is ignored when `coin_valid`=0.
- Subtraction cannot underflow because the selected coin is always ≤ `remaining`.
- Arithmetic is 32-bit unsigned, with no saturation needed. `coin_count` wraps modulo 2^32; not reachable in practice.
- `fault` holds until the next accepted `start` or reset.
- Reset, asserted at any time including mid-payout:
  - state goes to IDLE immediately (asynchronous);
  - `coin_valid`, `busy`, `done` and `fault` go to 0;
  - `remaining`, `coin_count` and `coin_type` go to 0.
  - No partial coin is reported.

## Timing
- `start` sampled at edge E0:
  - `busy`=1 from E0+1;
  - `coin_valid`=1 from E0+2.
- Each coin takes a minimum of 2 cycles (SELECT, then EMIT with `coin_ack` tied high).
- For N coins with immediate ack, `done` is high during the cycle after edge E0+2N. `busy` falls at edge E0+2N+1.
- `amount`=0: `done` is high during the cycle after E0; `coin_valid` never asserts.
- `coin_valid` falls on the edge that samples `coin_ack`=1. `remaining` and `coin_count` update on that same edge.
- Timeout: with `coin_ack` held 0, `coin_valid` stays high for exactly `TIMEOUT` cycles. `fault` and `done` then assert together in the next cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Greedy payout.** Reset low for 2 cycles, release, `amount`=67 with a `start` pulse, `coin_ack` tied 1.
  - `coin_type` sequence is 3,2,1,0,0; `coin_count`=5, `remaining`=0.
  - `done` pulses 10 cycles after the start edge; `fault`=0.
- **Zero change.** `amount`=0 with `start`.
  - `done` pulses the next cycle, `coin_valid` stays 0, `coin_count`=0.
- **Slow hopper.** `amount`=15, `coin_ack` raised 3 cycles after each `coin_valid` rise.
  - `coin_type` and `coin_valid` stay stable while waiting.
  - Coins are 2 then 1; `remaining` goes 15→5→0.
- **Timeout.** `amount`=10, `coin_ack` held 0.
  - `coin_valid` is high for 16 cycles, then `fault`=1 and `done` pulse.
  - `remaining`=10, `coin_count`=0.
  - A following `start` with `amount`=1 clears `fault`.
- **Start while busy.** `amount`=100; mid-payout apply `start` with `amount`=7.
  - The second request is ignored: coins are 3,3, `done` pulses once, `coin_count`=2.
- **Reset mid-operation.** `amount`=60; assert reset during the second EMIT.
  - All outputs go to 0 in the same cycle without waiting for a clock edge.
  - After release, a `start` with `amount`=6 pays out 1,0 normally.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin payout engine: greedy 50/10/5/1 selection, one coin per valid/ack
// handshake with a per-coin timeout that aborts the payout with a sticky fault.
module change_dispenser #(
   parameter int TIMEOUT = 16,
   parameter int V3      = 50,
   parameter int V2      = 10,
   parameter int V1      = 5,
   parameter int V0      = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] amount,
   input  logic        coin_ack,
   output logic        coin_valid,
   output logic [1:0]  coin_type,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] remaining,
   output logic [31:0] coin_count
);

   typedef enum logic [1:0] {IDLE, SELECT, EMIT, FINISH} state_t;

   state_t      state_reg, state_next;
   logic [31:0] remaining_next, count_next;
   logic [31:0] timer_reg, timer_next;
   logic [31:0] coin_value, paid;
   logic [1:0]  type_next;
   logic        fault_next;

   always_comb begin
      case (coin_type)
         2'd3:    coin_value = 32'(V3);
         2'd2:    coin_value = 32'(V2);
         2'd1:    coin_value = 32'(V1);
         default: coin_value = 32'(V0);
      endcase
   end

   // The selected coin never exceeds remaining, so this cannot underflow.
   assign paid = remaining - coin_value;

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining;
      count_next     = coin_count;
      timer_next     = timer_reg;
      type_next      = coin_type;
      fault_next     = fault;
      case (state_reg)
         IDLE: begin
            if (start) begin
               remaining_next = amount;
               count_next     = 32'd0;
               fault_next     = 1'b0;
               state_next     = (amount == 32'd0) ? FINISH : SELECT;
            end
         end
         SELECT: begin
            if (remaining >= 32'(V3))
               type_next = 2'd3;
            else if (remaining >= 32'(V2))
               type_next = 2'd2;
            else if (remaining >= 32'(V1))
               type_next = 2'd1;
            else
               type_next = 2'd0;
            timer_next = 32'd0;
            state_next = EMIT;
         end
         EMIT: begin
            if (coin_ack) begin
               remaining_next = paid;
               count_next     = coin_count + 32'd1;
               state_next     = (paid == 32'd0) ? FINISH : SELECT;
            end else if (timer_reg == 32'(TIMEOUT - 1)) begin
               fault_next = 1'b1;
               state_next = FINISH;
            end else begin
               timer_next = timer_reg + 32'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake/status flags are decoded from the next state so they leave a flop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         remaining  <= 32'd0;
         coin_count <= 32'd0;
         timer_reg  <= 32'd0;
         coin_type  <= 2'd0;
         fault      <= 1'b0;
         coin_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_reg  <= state_next;
         remaining  <= remaining_next;
         coin_count <= count_next;
         timer_reg  <= timer_next;
         coin_type  <= type_next;
         fault      <= fault_next;
         coin_valid <= (state_next == EMIT);
         busy       <= (state_next != IDLE);
         done       <= (state_next == FINISH);
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random payouts checked
// against a division-based greedy change model.
module tb_change_dispenser;

   localparam int TIMEOUT = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] amount = 32'd0;
   logic        coin_ack = 1'b0;
   logic        coin_valid, busy, done, fault;
   logic [1:0]  coin_type;
   logic [31:0] remaining, coin_count;

   int compared   = 0;
   int mismatched = 0;
   int coin_val[4] = '{1, 5, 10, 50};

   change_dispenser #(.TIMEOUT(TIMEOUT), .V3(50), .V2(10), .V1(5), .V0(1)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .amount     (amount),
      .coin_ack   (coin_ack),
      .coin_valid (coin_valid),
      .coin_type  (coin_type),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .remaining  (remaining),
      .coin_count (coin_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(coin_valid), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_fault"}, 32'(fault), 0);
      chk({tag, "_rem"},   remaining, 0);
      chk({tag, "_cnt"},   coin_count, 0);
      chk({tag, "_type"},  32'(coin_type), 0);
   endtask

   // One payout. dly_max=0 holds coin_ack high throughout; otherwise each coin
   // is acked after a random 0..dly_max cycle wait. no_ack forces a timeout.
   task automatic pay(input logic [31:0] amt, input int dly_max, input bit no_ack,
                      input bit mid_start);
      int q[$];
      int r, ncoins, exp_cnt, wait_c, dly, cyc, valid_total;
      logic [31:0] exp_rem;
      bit acked, got_done, ms_done;
      // Greedy change as plain division over the denominations.
      r = int'(amt);
      repeat (r / 50) q.push_back(3);
      r = r % 50;
      repeat (r / 10) q.push_back(2);
      r = r % 10;
      repeat (r / 5) q.push_back(1);
      repeat (r % 5) q.push_back(0);
      ncoins = q.size();

      @(negedge clock);
      start    = 1'b1;
      amount   = amt;
      coin_ack = (dly_max == 0) && !no_ack;
      @(negedge clock);
      start  = 1'b0;
      amount = $urandom;
      cyc = 1;
      chk("start_busy",  32'(busy), 1);
      chk("start_fault", 32'(fault), 0);
      chk("start_cnt",   coin_count, 0);
      chk("start_rem",   remaining, amt);
      if (amt != 0) chk("start_novalid", 32'(coin_valid), 0);

      exp_rem = amt; exp_cnt = 0; wait_c = 0; valid_total = 0;
      acked = 0; got_done = 0; ms_done = 0;
      dly = (dly_max == 0) ? 0 : int'($urandom_range(0, dly_max));
      while (!got_done && cyc < 2000) begin
         start = 1'b0;
         if (acked) begin
            if (q.size() > 0) begin
               exp_rem = exp_rem - 32'(coin_val[q[0]]);
               void'(q.pop_front());
            end
            exp_cnt++;
            acked = 0;
            if (dly_max != 0) coin_ack = 1'b0;
            chk("coin_rem",   remaining, exp_rem);
            chk("coin_cnt",   coin_count, 32'(exp_cnt));
            chk("valid_fall", 32'(coin_valid), 0);
         end
         if (done) begin
            got_done = 1;
            chk("done_busy",  32'(busy), 1);
            chk("done_fault", 32'(fault), 32'(no_ack && amt != 0));
            chk("done_rem",   remaining, (no_ack) ? amt : 32'd0);
            chk("done_cnt",   coin_count, 32'(exp_cnt));
            chk("done_valid", 32'(coin_valid), 0);
            if (no_ack && amt != 0) begin
               chk("timeout_len", 32'(valid_total), 32'(TIMEOUT));
            end else begin
               chk("done_coins", 32'(exp_cnt), 32'(ncoins));
               if (dly_max == 0) begin
                  chk("done_latency", 32'(cyc), 32'(2 * ncoins + 1));
                  chk("valid_cycles", 32'(valid_total), 32'(ncoins));
               end
            end
         end else if (coin_valid) begin
            valid_total++;
            if (q.size() > 0) chk("coin_type", 32'(coin_type), 32'(q[0]));
            else chk("coin_extra", 32'(coin_valid), 0);
            if (mid_start && !ms_done && exp_cnt == 1) begin
               start  = 1'b1;
               amount = 32'd7;
               ms_done = 1;
            end
            if (!no_ack) begin
               if (wait_c == dly) begin
                  coin_ack = 1'b1;
                  acked = 1;
                  wait_c = 0;
                  dly = (dly_max == 0) ? 0 : int'($urandom_range(0, dly_max));
               end else begin
                  wait_c++;
               end
            end
         end else begin
            chk("busy_hold", 32'(busy), 1);
         end
         if (!got_done) begin
            @(negedge clock);
            cyc++;
         end
      end
      if (!got_done) chk("done_bound", 32'(got_done), 1);
      coin_ack = 1'b0;
      @(negedge clock);
      chk("done_pulse", 32'(done), 0);
      chk("idle_busy",  32'(busy), 0);
      $display("payout amount=%0d coins=%0d count=%0d fault=%0b cycles=%0d",
               amt, ncoins, coin_count, fault, cyc);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk_all_zero("reset");
      reset = 1'b1;

      pay(32'd67, 0, 0, 0);    // greedy 3,2,1,0,0
      pay(32'd0, 0, 0, 0);     // zero change
      pay(32'd15, 3, 0, 0);    // slow hopper
      pay(32'd10, 0, 1, 0);    // timeout
      pay(32'd1, 0, 0, 0);     // clears fault
      pay(32'd100, 0, 0, 1);   // start while busy is ignored

      // Reset during the second EMIT of a 60 payout.
      @(negedge clock);
      start = 1'b1; amount = 32'd60; coin_ack = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (!(coin_valid && coin_count == 32'd1) && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("reach_emit2", 32'(coin_valid && coin_count == 32'd1), 1);
      #2 reset = 1'b0;
      #1 chk_all_zero("async_reset");
      coin_ack = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      $display("reset mid-payout checked");
      pay(32'd6, 0, 0, 0);

      for (int i = 0; i < 12; i++)
         pay(32'($urandom_range(0, 300)), int'($urandom_range(0, 3)), 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
